// File: rtl/lss5_pkg.sv
// Shared definitions for the 5-bit LSS sequence checker: width, default seed,
// next-state function and FSM state encoding.
package lss5_pkg;

  localparam int LSS_W = 5;
  localparam logic [LSS_W-1:0] SEED_DEF = 5'b11111;

  // One step of the generator: s0'=s4, s1'=s0, s2'=s1, s3'=s2|s4, s4'=s3^s4
  function automatic logic [LSS_W-1:0] lss5_next(input logic [LSS_W-1:0] s);
    logic [LSS_W-1:0] n;
    n[0] = s[4];
    n[1] = s[0];
    n[2] = s[1];
    n[3] = s[2] | s[4];
    n[4] = s[3] ^ s[4];
    return n;
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CHECK  = 2'b01,
    LOCKED = 2'b10
  } chk_state_t;

endpackage

// File: rtl/lss5_model.sv
// Local copy of the generator state. A load consumes the seed as the current
// (sync) bit, so the register takes next(seed) rather than seed itself; the
// expected bit for the following cycle is then available on exp_bit_o.
module lss5_model
  import lss5_pkg::*;
#(
  parameter logic [LSS_W-1:0] SEED = SEED_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic adv_i,
  output logic exp_bit_o
);

  logic [LSS_W-1:0] state_q, state_d;

  // Load takes priority over advance; otherwise the state holds
  always_comb begin
    state_d = state_q;
    if (load_i)
      state_d = lss5_next(SEED);
    else if (adv_i)
      state_d = lss5_next(state_q);
  end

  // Model register, reset to the seed
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= SEED;
    else
      state_q <= state_d;
  end

  assign exp_bit_o = state_q[4];

endmodule

// File: rtl/lss5_checker.sv
// Receive-end checker for the 5-bit LSS generator: aligns on din_sync,
// declares lock after LOCK_CNT consecutive matches, drops after LOSS_CNT
// consecutive mismatches and counts bit errors (saturating).
// Optional feature macro STICKY_ERR_EN adds the err_sticky output.
//
// state  | meaning
// IDLE   | not aligned; non-sync bits ignored, model held
// CHECK  | aligned on sync, counting consecutive matches toward lock
// LOCKED | lock declared; mismatches counted until loss
module lss5_checker
  import lss5_pkg::*;
#(
  parameter logic [LSS_W-1:0] SEED = SEED_DEF,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             din_sync,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state_o
`ifdef STICKY_ERR_EN
  ,
  output logic             err_sticky
`endif
);

  localparam logic [3:0] LOCK_TC = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_TC = 4'(LOSS_CNT);

  chk_state_t       state_q, state_d;
  logic [3:0]       match_q, match_d;
  logic [3:0]       miss_q, miss_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             locked_q, err_pulse_q;
  logic             model_bit, load, adv, exp_bit, mism, err;
  logic [3:0]       match_inc, miss_inc;

  lss5_model #(.SEED(SEED)) u_model (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .adv_i     (adv),
    .exp_bit_o (model_bit)
  );

  // The sync bit is always compared against the seed MSB, regardless of model state
  assign exp_bit   = din_sync ? SEED[4] : model_bit;
  assign mism      = din ^ exp_bit;
  assign match_inc = match_q + 4'd1;
  assign miss_inc  = miss_q + 4'd1;

  // Next-state, counter and model-control decode for one received bit
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    miss_d  = miss_q;
    load    = 1'b0;
    adv     = 1'b0;
    err     = 1'b0;
    if (din_valid) begin
      if (din_sync) begin
        load    = 1'b1;
        state_d = CHECK;
        err     = mism;
        match_d = mism ? 4'd0 : 4'd1;
        miss_d  = mism ? 4'd1 : 4'd0;
        if (mism && (LOSS_TC == 4'd1))
          state_d = IDLE;
      end else begin
        case (state_q)
          CHECK: begin
            adv = 1'b1;
            if (!mism) begin
              match_d = match_inc;
              miss_d  = 4'd0;
              if (match_inc == LOCK_TC)
                state_d = LOCKED;
            end else begin
              err     = 1'b1;
              match_d = 4'd0;
              miss_d  = miss_inc;
              if (miss_inc == LOSS_TC)
                state_d = IDLE;
            end
          end
          LOCKED: begin
            adv = 1'b1;
            if (!mism) begin
              miss_d = 4'd0;
            end else begin
              err    = 1'b1;
              miss_d = miss_inc;
              if (miss_inc == LOSS_TC)
                state_d = IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Saturating error count; clear wins over a same-cycle error
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr)
      err_cnt_d = '0;
    else if (err && (err_cnt_q != {ERR_W{1'b1}}))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  // State, counters and registered status
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      match_q     <= 4'd0;
      miss_q      <= 4'd0;
      err_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      err_cnt_q   <= err_cnt_d;
      locked_q    <= (state_d == LOCKED);
      err_pulse_q <= err;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign state_o   = state_q;

`ifdef STICKY_ERR_EN
  logic sticky_q;

  // Sticky error flag, cleared only by reset or clr
  always_ff @(posedge clk) begin
    if (rst)
      sticky_q <= 1'b0;
    else if (clr)
      sticky_q <= 1'b0;
    else if (err)
      sticky_q <= 1'b1;
  end

  assign err_sticky = sticky_q;
`endif

endmodule
